// File: rtl/instr_fetch.sv
// instr_fetch: instruction pointer and instruction register stage, rev 1.0.
// Optional pointer bounds checking is compiled in with INSTR_PTR_BOUNDS_EN.
`default_nettype none

module instr_fetch #(
  parameter int INSTR_WIDTH = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 65536,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_ptr_en,
  input  logic [1:0]             instr_ptr_load_en,
  input  logic                   instr_load_en,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [7:0]             opcode,
  output logic [31:0]            cmd_value,
  output logic [3:0]             reg0_addr,
  output logic [3:0]             reg1_addr,
  output logic [3:0]             reg_write_addr,
  output logic [ADDR_WIDTH-1:0]  jump_addr,
  output logic [31:0]            instr_count,
  output logic                   ptr_err
);

  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [31:0]            count_q;
  logic                   take_jump;
  logic                   ptr_step;

  assign opcode         = ir_q[INSTR_WIDTH-1  -: 8];
  assign cmd_value      = ir_q[INSTR_WIDTH-9  -: 32];
  assign reg0_addr      = ir_q[INSTR_WIDTH-41 -: 4];
  assign reg1_addr      = ir_q[INSTR_WIDTH-45 -: 4];
  assign reg_write_addr = ir_q[INSTR_WIDTH-49 -: 4];
  assign jump_addr      = ir_q[INSTR_WIDTH-53 -: ADDR_WIDTH];
  assign mem_addr       = ptr_q;
  assign instr_count    = count_q;

  // Load code 11 is reserved and falls through to the no-load behaviour.
  assign take_jump = (instr_ptr_load_en == 2'b01) ||
                     ((instr_ptr_load_en == 2'b10) && alu_out[0]);
  assign ptr_step  = take_jump || instr_ptr_en;

`ifdef INSTR_PTR_BOUNDS_EN
  localparam logic [ADDR_WIDTH:0] PTR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [ADDR_WIDTH:0] target;
  logic                err_q, err_d;

  // One extra bit so that an increment from the top address cannot wrap.
  always_comb begin
    target = take_jump ? {1'b0, jump_addr} : ({1'b0, ptr_q} + (ADDR_WIDTH+1)'(1));
    ptr_d  = ptr_q;
    err_d  = err_q;
    if (ptr_step) begin
      if (target >= PTR_LIMIT) begin
        err_d = 1'b1;
      end else begin
        ptr_d = target[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ptr_err = err_q;
`else
  always_comb begin
    ptr_d = ptr_q;
    if (take_jump) begin
      ptr_d = jump_addr;
    end else if (instr_ptr_en) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
    end
  end

  assign ptr_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (instr_load_en) begin
        ir_q    <= mem_data;
        count_q <= count_q + 32'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{alu_out[DATA_WIDTH-1:1], ir_q[INSTR_WIDTH-53-ADDR_WIDTH:0]} ^
                       (MEM_DEPTH == 0);

endmodule

`default_nettype wire
